// File: rtl/adder_arbiter_if.sv
// Request, shared-adder and response signals of adder_arbiter.
// slave = arbiter side, master = requesters + adder + response sink.
interface adder_arbiter_if #(
  parameter int DATA_WIDTH = 3,
  parameter int NUM_REQ    = 4
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;

  logic [DATA_WIDTH-1:0]         adder_a;
  logic [DATA_WIDTH-1:0]         adder_b;
  logic [DATA_WIDTH-1:0]         adder_result;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  adder_result,
    input  rsp_ready,
    output req_ready,
    output adder_a,
    output adder_b,
    output rsp_valid,
    output rsp_id,
    output rsp_data
  );

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output adder_result,
    output rsp_ready,
    input  req_ready,
    input  adder_a,
    input  adder_b,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_data
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one registered adder among NUM_REQ requesters.
// Define ADDER_ARBITER_FORMAL_EN to compile in the formal properties.
module adder_arbiter #(
  parameter int DATA_WIDTH = 3,
  parameter int NUM_REQ    = 4
) (
  input logic          clk,
  input logic          reset,
  adder_arbiter_if.slave bus
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]            state;
  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   gnt;
  logic [ID_WIDTH-1:0]   ptr_nxt;
  logic                  gnt_vld;
  logic [NUM_REQ-1:0]    ready;
  logic                  req_hs;
  logic                  rsp_hs;

  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [DATA_WIDTH-1:0] add_a_q;
  logic [DATA_WIDTH-1:0] add_b_q;
  logic                  rsp_valid_q;
  logic [ID_WIDTH-1:0]   rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_q;
  logic                  rsp_first;
  logic [DATA_WIDTH-1:0] rsp_data;

  // Scan from ptr upward; descending loop so the nearest index wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        gnt     = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (!reset && state == IDLE && gnt_vld)
      ready[gnt] = 1'b1;
  end

  assign ptr_nxt = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
  assign sel_a   = bus.req_a[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_b   = bus.req_b[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
  assign req_hs  = |(bus.req_valid & ready);
  assign rsp_hs  = rsp_valid_q && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_q       <= '0;
      rsp_first   <= 1'b0;
    end else begin
      rsp_first <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_hs) begin
            add_a_q  <= sel_a;
            add_b_q  <= sel_b;
            rsp_id_q <= gnt;
            ptr      <= ptr_nxt;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_valid_q <= 1'b1;
          rsp_first   <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          rsp_q <= rsp_data;
          if (rsp_hs) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // First RESP cycle forwards the fresh adder output; later cycles hold it.
  assign rsp_data = rsp_first ? bus.adder_result : rsp_q;

  assign bus.req_ready = ready;
  assign bus.adder_a   = add_a_q;
  assign bus.adder_b   = add_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data;

`ifdef ADDER_ARBITER_FORMAL_EN
  logic                  f_past_valid;
  logic                  f_busy;
  logic [DATA_WIDTH-1:0] f_a;
  logic [DATA_WIDTH-1:0] f_b;
  logic [3:0]            f_wait [NUM_REQ];

  always_ff @(posedge clk) begin
    if (reset) begin
      f_past_valid <= 1'b1;
      f_busy       <= 1'b0;
      f_a          <= '0;
      f_b          <= '0;
    end else begin
      if (req_hs) begin
        f_busy <= 1'b1;
        f_a    <= sel_a;
        f_b    <= sel_b;
      end else if (rsp_hs) begin
        f_busy <= 1'b0;
      end
    end
  end

  // Operations served to others while requester i kept waiting.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fair
    always_ff @(posedge clk) begin
      if (reset || (req_hs && int'(gnt) == i) || !bus.req_valid[i])
        f_wait[i] <= '0;
      else if (req_hs && f_wait[i] != 4'hf)
        f_wait[i] <= f_wait[i] + 4'd1;
    end

    a_fair: assert property (@(posedge clk) disable iff (reset)
      f_past_valid |-> int'(f_wait[i]) < NUM_REQ);
  end

  a_onehot: assert property (@(posedge clk)
    $onehot0(bus.req_ready));

  a_sum: assert property (@(posedge clk) disable iff (reset)
    f_past_valid && rsp_first
      |-> rsp_data == DATA_WIDTH'(f_a + f_b));

  a_stable: assert property (@(posedge clk) disable iff (reset)
    f_past_valid && rsp_valid_q && !bus.rsp_ready
      |=> rsp_valid_q && $stable(rsp_id_q) && $stable(rsp_data));

  a_no_orphan: assert property (@(posedge clk) disable iff (reset)
    f_past_valid && rsp_valid_q |-> f_busy);

  a_reset: assert property (@(posedge clk)
    f_past_valid && $past(reset)
      |-> state == IDLE && ptr == '0 && !rsp_valid_q
          && rsp_id_q == '0 && rsp_data == '0
          && add_a_q == '0 && add_b_q == '0);
`else
  // Formal properties compiled out.
`endif
endmodule
